time_counter: RTL and testbench

Keeps the alarm clock's current time of day as four BCD digits in 24-hour HH:MM form and drives the `current_time_*` digit inputs of the four-digit LCD driver. Derives one-second and one-minute pulses from the system clock with a prescaler. Loads a new time entered on the keypad and rejects illegal times.

---
 rtl/alarm_clock_pkg.sv | 56 +++++
 rtl/time_counter_if.sv | 32 +++
 rtl/second_tick_gen.sv | 34 +++
 rtl/time_counter.sv | 79 +++++++
 tb/tb_time_counter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared types, digit limits and BCD time helpers for the alarm clock.
package alarm_clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t ms_hr;
    bcd_t ls_hr;
    bcd_t ms_min;
    bcd_t ls_min;
  } hhmm_t;

  localparam bcd_t        MAX_HR_MS             = 4'd2;
  localparam bcd_t        MAX_HR_LS_AT_20       = 4'd3;
  localparam bcd_t        MAX_MIN_MS            = 4'd5;
  localparam bcd_t        MAX_DIGIT             = 4'd9;
  localparam int unsigned SECS_PER_MIN          = 60;
  localparam int unsigned DEFAULT_TICKS_PER_SEC = 256;

  function automatic logic hhmm_valid(hhmm_t t);
    logic hr_ok;
    if (t.ms_hr < MAX_HR_MS) begin
      hr_ok = (t.ls_hr <= MAX_DIGIT);
    end else begin
      hr_ok = (t.ms_hr == MAX_HR_MS) && (t.ls_hr <= MAX_HR_LS_AT_20);
    end
    return hr_ok && (t.ms_min <= MAX_MIN_MS) && (t.ls_min <= MAX_DIGIT);
  endfunction

  // Advance by one minute with BCD carries; 23:59 rolls to 00:00.
  function automatic hhmm_t hhmm_advance(hhmm_t t);
    hhmm_t n;
    n = t;
    if (t.ls_min != MAX_DIGIT) begin
      n.ls_min = t.ls_min + 4'd1;
    end else begin
      n.ls_min = '0;
      if (t.ms_min != MAX_MIN_MS) begin
        n.ms_min = t.ms_min + 4'd1;
      end else begin
        n.ms_min = '0;
        if ((t.ms_hr == MAX_HR_MS) && (t.ls_hr == MAX_HR_LS_AT_20)) begin
          n.ms_hr = '0;
          n.ls_hr = '0;
        end else if (t.ls_hr == MAX_DIGIT) begin
          n.ls_hr = '0;
          n.ms_hr = t.ms_hr + 4'd1;
        end else begin
          n.ls_hr = t.ls_hr + 4'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/time_counter_if.sv
// Keypad load, mode and LCD digit signals of the time counter.
interface time_counter_if;

  logic                 load_new_c;
  alarm_clock_pkg::bcd_t new_current_time_ms_hr;
  alarm_clock_pkg::bcd_t new_current_time_ls_hr;
  alarm_clock_pkg::bcd_t new_current_time_ms_min;
  alarm_clock_pkg::bcd_t new_current_time_ls_min;
  logic                 fast_watch;
  alarm_clock_pkg::bcd_t current_time_ms_hr;
  alarm_clock_pkg::bcd_t current_time_ls_hr;
  alarm_clock_pkg::bcd_t current_time_ms_min;
  alarm_clock_pkg::bcd_t current_time_ls_min;
  logic                 one_second;
  logic                 one_minute;
  logic                 load_error;

  modport master (
    output load_new_c, new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min, fast_watch,
    input  current_time_ms_hr, current_time_ls_hr, current_time_ms_min,
           current_time_ls_min, one_second, one_minute, load_error
  );

  modport slave (
    input  load_new_c, new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min, fast_watch,
    output current_time_ms_hr, current_time_ls_hr, current_time_ms_min,
           current_time_ls_min, one_second, one_minute, load_error
  );

endinterface

// File: rtl/second_tick_gen.sv
// Prescaler: flags the cycle that ends each second; clear_i restarts the count.
module second_tick_gen #(
  parameter int unsigned TicksPerSec = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned           CntW   = $clog2(TicksPerSec);
  localparam logic [CntW-1:0]       CntMax = CntW'(TicksPerSec - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A clear wins over a terminal count so a load never produces a second event.
  assign tick_o = (cnt_q == CntMax) && !clear_i;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/time_counter.sv
// HH:MM BCD time of day with second/minute pulses and validated keypad load.
module time_counter
  import alarm_clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
  input  logic         clock,
  input  logic         reset_n,
  time_counter_if.slave bus
);

  localparam logic [5:0] SecLast = 6'(SECS_PER_MIN - 1);

  hhmm_t      new_time;
  hhmm_t      time_q, time_d;
  logic [5:0] sec_q, sec_d;
  logic       one_second_q, one_minute_q, load_error_q;
  logic       load_ok, load_bad;
  logic       sec_event, sec_wrap, min_event;

  assign new_time = {bus.new_current_time_ms_hr, bus.new_current_time_ls_hr,
                     bus.new_current_time_ms_min, bus.new_current_time_ls_min};

  assign load_ok  = bus.load_new_c && hhmm_valid(new_time);
  assign load_bad = bus.load_new_c && !hhmm_valid(new_time);

  second_tick_gen #(
    .TicksPerSec(TICKS_PER_SEC)
  ) u_tick (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .clear_i(load_ok),
    .tick_o (sec_event)
  );

  assign sec_wrap  = sec_event && (sec_q == SecLast);
  assign min_event = sec_event && (sec_wrap || bus.fast_watch);

  always_comb begin
    sec_d  = sec_q;
    time_d = time_q;
    if (load_ok) begin
      sec_d  = '0;
      time_d = new_time;
    end else begin
      if (sec_event) begin
        sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
      end
      if (min_event) begin
        time_d = hhmm_advance(time_q);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      time_q       <= '0;
      sec_q        <= '0;
      one_second_q <= 1'b0;
      one_minute_q <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      time_q       <= time_d;
      sec_q        <= sec_d;
      one_second_q <= sec_event;
      one_minute_q <= min_event;
      load_error_q <= load_bad;
    end
  end

  assign bus.current_time_ms_hr  = time_q.ms_hr;
  assign bus.current_time_ls_hr  = time_q.ls_hr;
  assign bus.current_time_ms_min = time_q.ms_min;
  assign bus.current_time_ls_min = time_q.ls_min;
  assign bus.one_second          = one_second_q;
  assign bus.one_minute          = one_minute_q;
  assign bus.load_error          = load_error_q;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter with TICKS_PER_SEC = 4.
module tb_time_counter;

  localparam int unsigned TPS = 4;

  typedef struct packed {
    int unsigned edge_no;
    logic        sec;
    logic        min;
    logic        err;
    logic [15:0] tm;
  } ev_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  time_counter_if bus ();

  time_counter #(
    .TICKS_PER_SEC(TPS)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Edges since reset release; edge 1 is the first rising edge after release.
  int unsigned edge_cnt;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  logic [15:0] bad_tbl [5] = '{16'h2400, 16'h1960, 16'h19A0, 16'h3000, 16'h120A};

  function automatic logic [15:0] cur_time();
    return {bus.current_time_ms_hr, bus.current_time_ls_hr,
            bus.current_time_ms_min, bus.current_time_ls_min};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int unsigned e, input logic s, input logic m, input logic er,
                         input logic [15:0] tm);
    ev_t ev;
    ev = '{edge_no: e, sec: s, min: m, err: er, tm: tm};
    sb_q.push_back(ev);
  endtask

  // Applies a load at a falling edge; returns at the falling edge after it was sampled.
  task automatic do_load(input logic [15:0] t);
    bus.new_current_time_ms_hr  = t[15:12];
    bus.new_current_time_ls_hr  = t[11:8];
    bus.new_current_time_ms_min = t[7:4];
    bus.new_current_time_ls_min = t[3:0];
    bus.load_new_c = 1'b1;
    @(negedge clock);
    bus.load_new_c = 1'b0;
  endtask

  // Monitor: every pulse on the outputs must match the next scoreboard entry.
  initial begin
    ev_t got;
    ev_t exp_ev;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && (bus.one_second || bus.one_minute || bus.load_error)) begin
        got = '{edge_no: edge_cnt, sec: bus.one_second, min: bus.one_minute,
                err: bus.load_error, tm: cur_time()};
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got edge %0d sec %b min %b err %b time %h, expected none",
                   got.edge_no, got.sec, got.min, got.err, got.tm);
        end else begin
          exp_ev = sb_q.pop_front();
          if (got !== exp_ev) begin
            n_fail++;
            $display("FAIL event: got edge %0d sec %b min %b err %b time %h, expected edge %0d sec %b min %b err %b time %h",
                     got.edge_no, got.sec, got.min, got.err, got.tm,
                     exp_ev.edge_no, exp_ev.sec, exp_ev.min, exp_ev.err, exp_ev.tm);
          end
        end
      end
    end
  end

  initial begin
    bus.load_new_c              = 1'b0;
    bus.new_current_time_ms_hr  = '0;
    bus.new_current_time_ls_hr  = '0;
    bus.new_current_time_ms_min = '0;
    bus.new_current_time_ls_min = '0;
    bus.fast_watch              = 1'b0;

    #1 reset_n = 1'b0;
    #2;
    check("reset_time", 32'(cur_time()), 32'h0000);
    check("reset_pulses", 32'({bus.one_second, bus.one_minute, bus.load_error}), 32'd0);

    // Free run: a second every 4 edges, first minute on edge 240.
    @(negedge clock);
    for (int n = 1; n <= 60; n++) begin
      push_ev(4 * n, 1'b1, n == 60, 1'b0, (n == 60) ? 16'h0001 : 16'h0000);
    end
    reset_n = 1'b1;
    repeat (241) @(negedge clock);
    check("free_run_time", 32'(cur_time()), 32'h0001);

    // Fast watch: every second event is a minute event.
    bus.fast_watch = 1'b1;
    do_load(16'h2359);
    push_ev(edge_cnt + 4, 1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (4) @(negedge clock);
    do_load(16'h0959);
    push_ev(edge_cnt + 4, 1'b1, 1'b1, 1'b0, 16'h1000);
    repeat (4) @(negedge clock);
    do_load(16'h1959);
    push_ev(edge_cnt + 4, 1'b1, 1'b1, 1'b0, 16'h2000);
    repeat (4) @(negedge clock);

    // Rejected loads: error pulse next cycle, time and prescaler undisturbed.
    for (int i = 0; i < 5; i++) begin
      push_ev(edge_cnt + 1, 1'b0, 1'b0, 1'b1, 16'(16'h2000 + i));
      do_load(bad_tbl[i]);
      push_ev(edge_cnt + 3, 1'b1, 1'b1, 1'b0, 16'(16'h2001 + i));
      repeat (3) @(negedge clock);
    end

    // Load coinciding with the edge that would be a minute event.
    repeat (3) @(negedge clock);
    do_load(16'h1234);
    check("coincident_load_time", 32'(cur_time()), 32'h1234);
    check("coincident_load_minute", 32'(bus.one_minute), 32'd0);
    check("coincident_load_second", 32'(bus.one_second), 32'd0);
    push_ev(edge_cnt + 4, 1'b1, 1'b1, 1'b0, 16'h1235);
    repeat (4) @(negedge clock);

    // Mid-count asynchronous reset with prescaler at 2.
    repeat (2) @(negedge clock);
    check("pre_reset_time", 32'(cur_time()), 32'h1235);
    bus.fast_watch = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_reset_time", 32'(cur_time()), 32'h0000);
    check("mid_reset_pulses", 32'({bus.one_second, bus.one_minute, bus.load_error}), 32'd0);
    repeat (2) @(negedge clock);
    for (int n = 1; n <= 3; n++) begin
      push_ev(4 * n, 1'b1, 1'b0, 1'b0, 16'h0000);
    end
    reset_n = 1'b1;
    repeat (14) @(negedge clock);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
